// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter, with sticky overflow status.
// Optional low-level interrupt output irq_o is enabled by defining UART_TX_FIFO_IRQ_EN.
module uart_tx_fifo #(
    parameter int unsigned Depth     = 16,
    parameter int unsigned IrqThresh = 2,
    localparam int unsigned CntWidth = $clog2(Depth) + 1
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                flush_i,
    input  logic [7:0]          wr_data_i,
    input  logic                wr_en_i,
    output logic                full_o,
    output logic                overflow_o,
    input  logic                clear_overflow_i,
    output logic [7:0]          data_o,
    output logic                data_valid_o,
    input  logic                data_ready_i,
    output logic                empty_o,
`ifdef UART_TX_FIFO_IRQ_EN
    output logic                irq_o,
`endif
    output logic [CntWidth-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    localparam logic [0:0] EMPTY_S = 1'b0;
    localparam logic [0:0] VALID_S = 1'b1;

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : gen_depth_chk
        $error("Depth must be a power of 2 and at least 2");
    end
    if (IrqThresh >= Depth) begin : gen_thresh_chk
        $error("IrqThresh must be below Depth");
    end

    logic [7:0]          mem [Depth];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                ovf_q, ovf_d;
    logic [0:0]          state_q, state_d;
    logic                accept, pop;

    // full_q is the registered flag, so a write while full is dropped even if a pop coincides
    assign accept = wr_en_i && !full_q;
    assign pop    = (state_q == VALID_S) && data_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = EMPTY_S;
        end else begin
            if (accept) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)    rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({accept, pop})
                2'b10:   count_d = count_q + CntWidth'(1);
                2'b01:   count_d = count_q - CntWidth'(1);
                default: count_d = count_q;
            endcase
            case (state_q)
                EMPTY_S: if (accept) state_d = VALID_S;
                VALID_S: if (pop && !accept && count_q == CntWidth'(1)) state_d = EMPTY_S;
                default: state_d = EMPTY_S;
            endcase
        end
        full_d  = (count_d == CntWidth'(Depth));
        empty_d = (count_d == '0);
    end

    // Set wins over clear; a write discarded by flush is not an overflow
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en_i && full_q && !flush_i) ovf_d = 1'b1;
        else if (clear_overflow_i)         ovf_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            state_q  <= EMPTY_S;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && !flush_i) mem[wr_ptr_q] <= wr_data_i;
    end

    assign data_valid_o = (state_q == VALID_S);
    assign data_o       = data_valid_o ? mem[rd_ptr_q] : 8'h00;
    assign count_o      = count_q;
    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign overflow_o   = ovf_q;

`ifdef UART_TX_FIFO_IRQ_EN
    logic seen_q;
    logic irq_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            seen_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            seen_q <= seen_q | (accept && !flush_i);
            irq_q  <= (count_q <= CntWidth'(IrqThresh)) && seen_q;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed bench for uart_tx_fifo against a queue-based reference model.
// Define UART_TX_FIFO_IRQ_EN to also check irq_o.
module tb_uart_tx_fifo;

    localparam int unsigned Depth     = 16;
    localparam int unsigned IrqThresh = 2;
    localparam int unsigned CW        = $clog2(Depth) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_en = 1'b0;
    logic          full;
    logic          overflow;
    logic          clear_ovf = 1'b0;
    logic [7:0]    data;
    logic          data_valid;
    logic          data_ready = 1'b0;
    logic          empty;
    logic [CW-1:0] count;
`ifdef UART_TX_FIFO_IRQ_EN
    logic          irq;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] q[$];
    bit         ovf_m  = 1'b0;
    bit         seen_m = 1'b0;
    bit         irq_m  = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .Depth    (Depth),
        .IrqThresh(IrqThresh)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .flush_i         (flush),
        .wr_data_i       (wr_data),
        .wr_en_i         (wr_en),
        .full_o          (full),
        .overflow_o      (overflow),
        .clear_overflow_i(clear_ovf),
        .data_o          (data),
        .data_valid_o    (data_valid),
        .data_ready_i    (data_ready),
        .empty_o         (empty),
`ifdef UART_TX_FIFO_IRQ_EN
        .irq_o           (irq),
`endif
        .count_o         (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        int n = q.size();
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == Depth));
        check("valid", 32'(data_valid), 32'(n > 0));
        if (n > 0) check("data", 32'(data), 32'(q[0]));
        check("overflow", 32'(overflow), 32'(ovf_m));
`ifdef UART_TX_FIFO_IRQ_EN
        check("irq", 32'(irq), 32'(irq_m));
`endif
    endtask

    // Check the current outputs, then drive one cycle's inputs and advance the model
    task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit f, input bit c);
        bit full_m, acc, pp;
        @(negedge clk);
        compare_outputs();
        wr_en = w; wr_data = d; data_ready = r; flush = f; clear_ovf = c;
        full_m = (q.size() == Depth);
        acc    = w && !full_m;
        pp     = (q.size() > 0) && r;
        irq_m  = (q.size() <= IrqThresh) && seen_m;
        if (w && full_m && !f) ovf_m = 1'b1;
        else if (c)            ovf_m = 1'b0;
        if (f) begin
            q.delete();
        end else begin
            if (pp)  void'(q.pop_front());
            if (acc) begin
                q.push_back(d);
                seen_m = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, r, 1'b0, 1'b0);
    endtask

    initial begin
        #12;
        compare_outputs();
        check("reset_data", 32'(data), 32'h00);
        reset_n = 1'b1;

        // Single byte held while the transmitter is busy
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        idle(20, 1'b0);
        check("hold_data", 32'(data), 32'hA5);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("ovf_after_full", 32'(overflow), 32'h1);
        idle(18, 1'b1);
        check("empty_after_drain", 32'(empty), 32'h1);

        // Streaming with pointer wrap: count stays at one
        cycle(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);

        // Flush with coincident write; overflow still set from the fill test
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);
        check("ovf_kept_by_flush", 32'(overflow), 32'h1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset with bytes queued
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        compare_outputs();
        wr_en = 1'b0; data_ready = 1'b0; flush = 1'b0; clear_ovf = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async_valid", 32'(data_valid), 32'h0);
        check("async_count", 32'(count), 32'h0);
        check("async_empty", 32'(empty), 32'h1);
        q.delete(); ovf_m = 1'b0; seen_m = 1'b0; irq_m = 1'b0;
        #1 reset_n = 1'b1;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h3D, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);

`ifdef UART_TX_FIFO_IRQ_EN
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
        idle(6, 1'b1);
        check("irq_at_zero", 32'(irq), 32'h1);
`endif

        // Random traffic, biased first toward filling then toward draining
        for (int i = 0; i < 1000; i++) begin
            int wp = (i < 500) ? 70 : 35;
            int rp = (i < 500) ? 35 : 70;
            cycle($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
                  $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4);
        end
        idle(20, 1'b1);
        @(negedge clk);
        compare_outputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO sitting directly upstream of the UART transmitter. It accepts bytes from the register/bus side and presents them first-word-fall-through on a valid/ready handshake to the transmitter's data_i / data_valid_i / data_in_ready_o interface. It decouples bus writes from the serial bit rate and reports fill level and sticky overflow status.

Parameters:
Depth, 16, storage capacity in bytes; power of 2, minimum 2; total bytes held including the output register.
CntWidth, $clog2(Depth)+1, width of count_o; derived, never overridden.
IrqThresh, 2, low-level threshold for the optional interrupt; legal range 0..Depth-1.

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset; deassertion is synchronised by the integrator
flush_i  in  1  synchronous discard of all stored bytes
wr_data_i  in  8  byte to enqueue
wr_en_i  in  1  enqueue strobe, one byte per cycle
full_o  out  1  count_o == Depth
overflow_o  out  1  sticky: write attempted while full
clear_overflow_i  in  1  clears overflow_o
data_o  out  8  head byte, to transmitter data_i
data_valid_o  out  1  head byte valid, to transmitter data_valid_i
data_ready_i  in  1  from transmitter data_in_ready_o
empty_o  out  1  count_o == 0
count_o  out  CntWidth  bytes accepted and not yet consumed

Behaviour:
- Reset (async, reset_n_i low): count_o=0, empty_o=1, full_o=0, data_valid_o=0, data_o=8'h00, overflow_o=0, read and write pointers=0. Reset mid-transfer discards all contents immediately.
- Write accept: wr_en_i && !full_o at a clock edge. full_o is the registered value. A write while full is dropped even if a pop happens in the same cycle, and it sets overflow_o.
- Pop: data_valid_o && data_ready_i at a clock edge. The next byte, if any, appears on data_o in the following cycle with no bubble.
- Latency: a write into an empty FIFO in cycle N gives data_valid_o=1 with that byte on data_o in cycle N+1.
- While data_valid_o=1 and data_ready_i=0, data_o holds stable. data_valid_o never deasserts without a pop, except on flush or reset.
- Ordering is strict FIFO. Pointers are log2(Depth) bits and wrap modulo Depth.
- count_o is +1 on accept only, -1 on pop only, and unchanged on simultaneous accept and pop. empty_o and full_o are registered and consistent with count_o in the same cycle.
- Simultaneous write and pop with count_o=1: the written byte becomes the head in the next cycle and data_valid_o stays 1.
- Output stage FSM:
  - EMPTY_S to VALID_S on accept.
  - VALID_S to EMPTY_S on pop with count_o=1 and no accept.
  - Otherwise remains in VALID_S.
  - Any state goes to EMPTY_S on flush_i.
- flush_i has priority over writes and pops in the same cycle. The next cycle shows count_o=0, data_valid_o=0, pointers=0. A write coincident with flush is discarded and does not set overflow_o.
- Overflow: overflow_o is set the cycle after a dropped write. clear_overflow_i clears it; if a clear and a new overflow coincide, set wins. Flush does not clear overflow_o.

Optional Feature:
- Macro UART_TX_FIFO_IRQ_EN.
- Defined: adds output port irq_o (1 bit, reset 0), a registered level equal to (count_o <= IrqThresh) && tx_activity_seen. tx_activity_seen sets on the first accepted write after reset and clears on reset only. irq_o therefore asserts one cycle after count_o drops to IrqThresh and stays high until count_o exceeds IrqThresh.
- Undefined: the irq_o port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then write 8'hA5 in cycle N with data_ready_i=0: data_valid_o=1 and data_o=8'hA5 at N+1, held stable for 20 cycles; count_o=1.
- Fill 16 bytes 0x00..0x0F, then a 17th write of 0xFF: full_o=1, overflow_o=1 the next cycle. Drain with data_ready_i=1: output 0x00..0x0F in order, 0xFF never appears, empty_o=1 afterwards.
- Continuous write and pop every cycle for 40 bytes (pointer wrap): count_o stays 1, data stream is identical and in order, no bubbles.
- Load 5 bytes, assert flush_i together with wr_en_i (byte 0x77): the next cycle shows count_o=0 and data_valid_o=0; 0x77 is never output; overflow_o is unchanged.
- Drive reset_n_i low asynchronously between clock edges with 3 bytes queued: data_valid_o and count_o go to 0 immediately without a clock edge; after reset, the first written byte is the next one output.
- With UART_TX_FIFO_IRQ_EN and IrqThresh=2: write 4 bytes then drain; irq_o rises one cycle after count_o becomes 2 and stays high at count_o=0.
